// File: rtl/scma_pkg.sv
// Shared constants, FSM encoding and helpers for the SCMA host access scheduler.
package scma_pkg;

    localparam int CHIP_NUM = 16;
    localparam int ADDR_W   = 11;
    localparam int DIN_W    = 36;
    localparam int DOUT_W   = 32;
    localparam int CHIP_W   = $clog2(CHIP_NUM);
    localparam int AIN_W    = ADDR_W + CHIP_NUM;

    localparam logic [ADDR_W-1:0]   RD_ADDR_DEF      = 11'h002;
    localparam logic [ADDR_W-1:0]   STAT_ADDR_DEF    = 11'h7FF;
    localparam logic [CHIP_NUM-1:0] CHIP_MASK_DEF    = 16'hFFFF;
    localparam int                  WR_BURST_MAX_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        WR_CHK,
        WR_ISSUE,
        RD_PROBE,
        RD_CAPTURE,
        OUT_HOLD
    } state_t;

    typedef struct packed {
        logic [CHIP_W-1:0] chip;
        logic [ADDR_W-1:0] addr;
        logic [DIN_W-1:0]  data;
    } wr_req_t;

    function automatic logic [CHIP_NUM-1:0] onehot16(input logic [CHIP_W-1:0] idx);
        logic [CHIP_NUM-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/scma_rr_ptr.sv
// Round-robin helper: next enabled chip index strictly after ptr, wrapping.
// Returns ptr itself when it is the only enabled chip, or when no chip is enabled.
module scma_rr_ptr
    import scma_pkg::*;
(
    input  logic [CHIP_W-1:0]   ptr,
    input  logic [CHIP_NUM-1:0] mask,
    output logic [CHIP_W-1:0]   next_ptr
);

    logic              found;
    logic [CHIP_W-1:0] idx;

    // NOTE: every variable written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        next_ptr = ptr;
        found    = 1'b0;
        idx      = ptr;
        for (int i = 1; i <= CHIP_NUM; i++) begin
            idx = ptr + CHIP_W'(i);
            if (!found && mask[idx]) begin
                next_ptr = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scma_access_sched.sv
// Host-side scheduler for the SCMA array: serialises held writes onto the one-hot
// select bus, gated by the chip full flag, and round-robin polls enabled chips for results.
module scma_access_sched
    import scma_pkg::*;
#(
    parameter logic [ADDR_W-1:0]   RD_ADDR      = RD_ADDR_DEF,
    parameter logic [ADDR_W-1:0]   STAT_ADDR    = STAT_ADDR_DEF,
    parameter logic [CHIP_NUM-1:0] CHIP_MASK    = CHIP_MASK_DEF,
    parameter int                  WR_BURST_MAX = WR_BURST_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CHIP_W-1:0] wr_chip,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DIN_W-1:0]  wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CHIP_W-1:0] rd_chip,
    output logic [DOUT_W-1:0] rd_data,
    output logic [AIN_W-1:0]  a_in,
    output logic [DIN_W-1:0]  data_in,
    input  logic [DOUT_W-1:0] data_out,
    input  logic              empty,
    input  logic              full
);

    localparam int             BURST_W    = $clog2(WR_BURST_MAX + 1);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(WR_BURST_MAX - 1);
    localparam logic           MASK_ANY   = |CHIP_MASK;

    state_t               state, state_d;
    logic                 held, held_d;
    wr_req_t              req, req_d;
    logic [CHIP_W-1:0]    ptr, ptr_d, ptr_nxt, probe_ptr;
    logic [BURST_W-1:0]   burst, burst_d;
    logic [AIN_W-1:0]     a_in_d;
    logic [DIN_W-1:0]     data_in_d;
    logic                 wr_ready_d, rd_valid_d;
    logic                 wr_fire;

    scma_rr_ptr u_rr_ptr (
        .ptr      (ptr),
        .mask     (CHIP_MASK),
        .next_ptr (ptr_nxt)
    );

    assign wr_fire   = wr_valid & wr_ready;
    // The pointer may rest on a disabled chip only after reset; skip it when probing.
    assign probe_ptr = CHIP_MASK[ptr] ? ptr : ptr_nxt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            held     <= 1'b0;
            req      <= '0;
            ptr      <= '0;
            burst    <= '0;
            a_in     <= '0;
            data_in  <= '0;
            wr_ready <= 1'b0;
            rd_valid <= 1'b0;
            rd_chip  <= '0;
            rd_data  <= '0;
        end else begin
            state    <= state_d;
            held     <= held_d;
            req      <= req_d;
            ptr      <= ptr_d;
            burst    <= burst_d;
            a_in     <= a_in_d;
            data_in  <= data_in_d;
            wr_ready <= wr_ready_d;
            rd_valid <= rd_valid_d;
            if (state == RD_CAPTURE) begin
                rd_data <= data_out;
                rd_chip <= ptr;
            end
        end
    end

    always_comb begin
        state_d = state;
        held_d  = held;
        req_d   = req;
        ptr_d   = ptr;
        burst_d = burst;
        case (state)
            IDLE: begin
                if (wr_fire) begin
                    // Writes to disabled chips are accepted and dropped.
                    if (CHIP_MASK[wr_chip]) begin
                        req_d   = '{chip: wr_chip, addr: wr_addr, data: wr_data};
                        held_d  = 1'b1;
                        state_d = WR_CHK;
                    end
                end else if (held) begin
                    state_d = WR_CHK;
                end else if (MASK_ANY) begin
                    state_d = RD_PROBE;
                    ptr_d   = probe_ptr;
                    burst_d = '0;
                end
            end
            WR_CHK: begin
                if (!full) begin
                    state_d = WR_ISSUE;
                end else begin
                    // Poll the full chip so it can drain before the retry.
                    state_d = RD_PROBE;
                    ptr_d   = req.chip;
                    burst_d = '0;
                end
            end
            WR_ISSUE: begin
                held_d = 1'b0;
                if (burst == BURST_LAST) begin
                    state_d = RD_PROBE;
                    ptr_d   = probe_ptr;
                    burst_d = '0;
                end else begin
                    state_d = IDLE;
                    burst_d = burst + 1'b1;
                end
            end
            RD_PROBE: begin
                if (!empty) begin
                    state_d = RD_CAPTURE;
                end else begin
                    state_d = IDLE;
                    ptr_d   = ptr_nxt;
                end
            end
            RD_CAPTURE: begin
                state_d = OUT_HOLD;
                ptr_d   = ptr_nxt;
            end
            OUT_HOLD: begin
                if (rd_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output values for the coming state, registered alongside it.
    always_comb begin
        a_in_d     = '0;
        data_in_d  = '0;
        wr_ready_d = 1'b0;
        rd_valid_d = 1'b0;
        case (state_d)
            IDLE:       wr_ready_d = !held_d;
            WR_CHK:     a_in_d     = {onehot16(req_d.chip), STAT_ADDR};
            WR_ISSUE: begin
                a_in_d    = {onehot16(req_d.chip), req_d.addr};
                data_in_d = req_d.data;
            end
            RD_PROBE,
            RD_CAPTURE: a_in_d     = {onehot16(ptr_d), RD_ADDR};
            OUT_HOLD:   rd_valid_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_scma_access_sched.sv
// Directed bench for scma_access_sched with a behavioural array model; a second
// instance runs with CHIP_MASK=16'h0101 to cover masked polling.
module tb_scma_access_sched;
    import scma_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic              wr_valid, wr_ready, rd_valid, rd_ready, empty, full;
    logic [CHIP_W-1:0] wr_chip, rd_chip;
    logic [ADDR_W-1:0] wr_addr;
    logic [DIN_W-1:0]  wr_data, data_in;
    logic [DOUT_W-1:0] rd_data, data_out;
    logic [AIN_W-1:0]  a_in;

    logic              m_wr_valid, m_wr_ready, m_rd_valid;
    logic              m_rd_ready = 1'b0;
    logic              m_empty    = 1'b1;
    logic              m_full     = 1'b0;
    logic [CHIP_W-1:0] m_wr_chip, m_rd_chip;
    logic [ADDR_W-1:0] m_wr_addr;
    logic [DIN_W-1:0]  m_wr_data, m_data_in;
    logic [DOUT_W-1:0] m_rd_data;
    logic [DOUT_W-1:0] m_data_out = '0;
    logic [AIN_W-1:0]  m_a_in;

    // Array model: per-chip full / not-empty flags and result words.
    logic [CHIP_NUM-1:0] full_mask, ne_mask;
    logic [DOUT_W-1:0]   chip_data [CHIP_NUM];

    assign full  = |(a_in[AIN_W-1:ADDR_W] & full_mask);
    assign empty = ~|(a_in[AIN_W-1:ADDR_W] & ne_mask);
    always_comb begin
        data_out = '0;
        for (int i = 0; i < CHIP_NUM; i++)
            if (a_in[ADDR_W+i]) data_out = chip_data[i];
    end

    scma_access_sched dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chip(wr_chip),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_chip(rd_chip), .rd_data(rd_data),
        .a_in(a_in), .data_in(data_in), .data_out(data_out),
        .empty(empty), .full(full)
    );

    scma_access_sched #(.CHIP_MASK(16'h0101)) dut_m (
        .clk(clk), .rst(rst),
        .wr_valid(m_wr_valid), .wr_ready(m_wr_ready), .wr_chip(m_wr_chip),
        .wr_addr(m_wr_addr), .wr_data(m_wr_data),
        .rd_valid(m_rd_valid), .rd_ready(m_rd_ready), .rd_chip(m_rd_chip), .rd_data(m_rd_data),
        .a_in(m_a_in), .data_in(m_data_in), .data_out(m_data_out),
        .empty(m_empty), .full(m_full)
    );

    int n_vec = 0;
    int n_err = 0;
    int iss5 = 0, probe5 = 0, iss4 = 0, chk4 = 0, bad_m = 0;

    always @(negedge clk) begin
        if (a_in == {16'h0020, 11'h044}) iss5   <= iss5 + 1;
        if (a_in == {16'h0020, 11'h002}) probe5 <= probe5 + 1;
        if (a_in == {16'h0010, 11'h055}) iss4   <= iss4 + 1;
        if (a_in == {16'h0010, 11'h7FF}) chk4   <= chk4 + 1;
        if ((m_a_in[AIN_W-1:ADDR_W] & ~16'h0101) != '0) bad_m <= bad_m + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_write(input logic [CHIP_W-1:0] c, input logic [ADDR_W-1:0] a,
                              input logic [DIN_W-1:0] d);
        int n = 0;
        wr_chip  = c;
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wr_handshake", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_sel(input string tag, input logic [AIN_W-1:0] want);
        int n = 0;
        while (a_in !== want && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(tag, a_in, want);
    endtask

    initial begin
        logic [CHIP_NUM-1:0] exp_sel;
        int n_probe, issues, probes, tot_iss, chk4_snap;

        rst = 1'b1;
        wr_valid = 1'b0; wr_chip = '0; wr_addr = '0; wr_data = '0; rd_ready = 1'b0;
        m_wr_valid = 1'b0; m_wr_chip = '0; m_wr_addr = '0; m_wr_data = '0;
        full_mask = '0; ne_mask = '0;
        for (int i = 0; i < CHIP_NUM; i++) chip_data[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_a_in", a_in, 0);
        check("rst_data_in", data_in, 0);
        check("rst_wr_ready", wr_ready, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_chip", rd_chip, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_m_a_in", m_a_in, 0);
        rst = 1'b0;

        // Masked instance: probes alternate chips 0 and 8
        exp_sel = 16'h0001;
        n_probe = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_a_in[AIN_W-1:ADDR_W] != '0) begin
                check("m_probe_sel", m_a_in[AIN_W-1:ADDR_W], exp_sel);
                check("m_probe_addr", m_a_in[ADDR_W-1:0], 11'h002);
                exp_sel = (exp_sel == 16'h0001) ? 16'h0100 : 16'h0001;
                n_probe++;
            end
        end
        check("m_probe_count", n_probe, 10);

        // Write to disabled chip 3 on the masked instance is accepted and dropped
        m_wr_chip = 4'd3; m_wr_addr = 11'h033; m_wr_data = 36'h1; m_wr_valid = 1'b1;
        for (int i = 0; i < 10 && !m_wr_ready; i++) @(negedge clk);
        check("m_wr_accept", m_wr_ready, 1);
        @(negedge clk);
        m_wr_valid = 1'b0;

        // 1: plain write, bus cycle two cycles after handshake, one cycle wide
        send_write(4'd3, 11'h010, 36'h123456789);
        check("w1_chk_a_in", a_in, {16'h0008, 11'h7FF});
        check("w1_chk_data", data_in, 0);
        @(negedge clk);
        check("w1_iss_a_in", a_in, {16'h0008, 11'h010});
        check("w1_iss_data", data_in, 36'h123456789);
        @(negedge clk);
        check("w1_after_a_in", a_in, 0);
        check("w1_after_data", data_in, 0);

        // 2: write to a full chip is held, the chip is polled, then issued once
        full_mask = 16'h0020;
        send_write(4'd5, 11'h044, 36'hABC);
        check("w2_chk_a_in", a_in, {16'h0020, 11'h7FF});
        @(negedge clk);
        check("w2_probe_a_in", a_in, {16'h0020, 11'h002});
        check("w2_probe_wr_ready", wr_ready, 0);
        repeat (10) @(negedge clk);
        check("w2_no_issue_full", iss5, 0);
        full_mask = '0;
        repeat (30) @(negedge clk);
        check("w2_issued_once", iss5, 1);
        check("w2_probed", probe5 > 0, 1);

        // 3: result capture and hold under back-pressure
        chip_data[7] = 32'hDEADBEEF;
        ne_mask = 16'h0080;
        wait_sel("r3_probe", {16'h0080, 11'h002});
        check("r3_probe_valid", rd_valid, 0);
        @(negedge clk);
        check("r3_capture_a_in", a_in, {16'h0080, 11'h002});
        check("r3_capture_valid", rd_valid, 0);
        @(negedge clk);
        chip_data[7] = 32'h0;
        ne_mask = '0;
        for (int i = 0; i < 5; i++) begin
            check("r3_hold_valid", rd_valid, 1);
            check("r3_hold_chip", rd_chip, 7);
            check("r3_hold_data", rd_data, 32'hDEADBEEF);
            check("r3_hold_a_in", a_in, 0);
            @(negedge clk);
        end
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        check("r3_release_valid", rd_valid, 0);

        // 4: continuous writes force a probe slot after every 4th issue
        for (int i = 0; i < 20 && !wr_ready; i++) @(negedge clk);
        check("b4_start_ready", wr_ready, 1);
        wr_chip = 4'd2; wr_addr = 11'h100; wr_data = 36'h5A; wr_valid = 1'b1;
        issues = 0; probes = 0; tot_iss = 0;
        for (int i = 1; i <= 26; i++) begin
            @(negedge clk);
            if (a_in == {16'h0004, 11'h100}) begin
                issues++;
            end else if (a_in[ADDR_W-1:0] == 11'h002 && a_in[AIN_W-1:ADDR_W] != '0) begin
                check("b4_burst_len", issues, 4);
                check("b4_probe_wr_ready", wr_ready, 0);
                probes++;
                tot_iss += issues;
                issues = 0;
            end
        end
        wr_valid = 1'b0;
        check("b4_probe_count", probes, 2);
        check("b4_issue_count", tot_iss, 8);

        // 6a: reset during RD_CAPTURE abandons the bus cycle
        chip_data[9] = 32'h12345678;
        ne_mask = 16'h0200;
        wait_sel("r6_probe", {16'h0200, 11'h002});
        @(negedge clk);
        check("r6_capture_a_in", a_in, {16'h0200, 11'h002});
        rst = 1'b1;
        @(negedge clk);
        check("r6_rst_a_in", a_in, 0);
        check("r6_rst_rd_valid", rd_valid, 0);
        check("r6_rst_wr_ready", wr_ready, 0);
        check("r6_rst_rd_data", rd_data, 0);
        ne_mask = '0;
        rst = 1'b0;

        // 6b: reset while a write is held discards it
        full_mask = 16'h0010;
        send_write(4'd4, 11'h055, 36'h77);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("h6_rst_a_in", a_in, 0);
        check("h6_rst_wr_ready", wr_ready, 0);
        check("h6_rst_rd_valid", rd_valid, 0);
        full_mask = '0;
        chk4_snap = chk4;
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("h6_no_stale_issue", iss4, 0);
        check("h6_no_stale_chk", chk4 - chk4_snap, 0);

        check("m_never_disabled", bad_m, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
